inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage: owns the program counter register, issues sequential reads to the instruction memory and buffers returned instructions for the decode stage behind a valid/ready handshake. It consumes the same halt/branch/branch_addr controls that drive the PC-increment logic and holds the PC value those controls act on. The block sits between the instruction memory port and decode.

## Interface
- INST_ADDR_WIDTH, 16, PC and memory address width
- INST_WIDTH, 16, instruction word width
- NUM_BYTES_IN_INST, 2, PC increment per sequential fetch
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- halt  in  1  stop issuing fetches; priority over branch
- branch  in  1  redirect PC to branch_addr and flush
- branch_addr  in  INST_ADDR_WIDTH  redirect target
- imem_req  out  1  read request this cycle
- imem_addr  out  INST_ADDR_WIDTH  read address (= PC)
- imem_rdata  in  INST_WIDTH  read data, fixed 1-cycle latency after imem_req
- inst_valid  out  1  buffer non-empty
- inst  out  INST_WIDTH  head instruction
- inst_pc  out  INST_ADDR_WIDTH  address of head instruction
- inst_ready  in  1  decode accepts head (pop when inst_valid & inst_ready)

## Operation
- FSM states: BOOT, RUN, HALTED. Reset -> BOOT; BOOT -> RUN after one cycle.
- RUN: imem_req = 1 when (count + inflight - pop) < 2, where count = buffer occupancy (0..2), inflight = request issued last cycle, pop = inst_valid & inst_ready. On request, PC <= PC + NUM_BYTES_IN_INST, mod 2^INST_ADDR_WIDTH (wraps silently).
- Response: cycle after a non-dropped request, {imem_rdata, request address} written into buffer.
- halt in RUN or BOOT: no request that cycle; -> HALTED. PC held. In-flight response and buffered entries still delivered.
- HALTED: no requests; branch with halt low -> RUN with redirect; otherwise stay.
- branch (halt low): PC <= branch_addr, buffer cleared, in-flight response dropped, no request that cycle; fetch from branch_addr next cycle. Pop in same cycle is ignored (entry flushed).
- halt & branch together: halt wins, branch ignored.
- Reset mid-operation: all state cleared immediately, in-flight response discarded.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0; PC = RESET_PC, count 0, inflight 0, state BOOT.
- rst_n released before edge 0: cycle 0 BOOT; cycle 1 imem_req=1, imem_addr=RESET_PC; cycle 2 data returned; cycle 3 inst_valid=1.
- Request-to-inst_valid latency 2 cycles; branch-to-first-target-inst_valid 3 cycles.
- Throughput one instruction/cycle with inst_ready held high; buffer never exceeds 2.
- imem_req, imem_addr combinational from state; imem_req depends combinationally on inst_ready.

## Configuration
- FETCH_PERF_CNT_EN defined: extra outputs perf_fetched (16 b, increments on each pop) and perf_flushes (16 b, increments on each accepted branch); both reset to 0, saturate at 0xFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: FSM state encoding (BOOT/RUN/HALTED), buffer depth constant 2, default RESET_PC.
- Sub-module fetch_fifo: 2-entry buffer of {inst, pc} with push, pop, flush, count; flush overrides push/pop.

## Test plan
- Reset, inst_ready=1, imem returns addr-as-data -> inst_valid at cycle 3, inst_pc sequence 0x0000, 0x0002, 0x0004 one per cycle.
- inst_ready=0 from cycle 3 -> exactly 2 entries buffered, imem_req stays 0; release -> 0x0000, 0x0002, 0x0004 in order, none lost or duplicated.
- branch, branch_addr=0x0100 while a request is in flight -> stale data never surfaces; next inst_pc = 0x0100 three cycles later.
- halt at PC 0x0006 -> no further requests, buffered 0x0002/0x0004 still drain; then branch to 0x0040 -> resumes fetching 0x0040.
- halt & branch same cycle, branch_addr=0x0200 -> HALTED, PC unchanged, no flush.
- PC=0xFFFE sequential fetch -> next imem_addr 0x0000; with FETCH_PERF_CNT_EN, 3 pops and 1 branch -> perf_fetched=3, perf_flushes=1.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch stage.
// Contents: address/instruction widths, PC step, buffer depth, default reset PC,
//           fetch FSM state encoding and the buffered {inst, pc} entry type.
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_WIDTH   = 16;
  localparam int unsigned INST_WIDTH        = 16;
  localparam int unsigned NUM_BYTES_IN_INST = 2;
  localparam int unsigned FIFO_DEPTH        = 2;
  localparam int unsigned FIFO_CNT_W        = 2;
  localparam int unsigned OCC_W             = 3;
  localparam int unsigned PERF_CNT_W        = 16;

  localparam logic [INST_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Purpose: bundle of the fetch stage's control, imem and decode signals.
// master modport: fetch stage (drives imem_req/imem_addr and the decode-side
//                 inst_valid/inst/inst_pc; receives halt/branch/branch_addr,
//                 imem_rdata and inst_ready).
// slave modport:  the surrounding pipeline / memory, mirrored directions.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                       halt;
  logic                       branch;
  logic [INST_ADDR_WIDTH-1:0] branch_addr;
  logic                       imem_req;
  logic [INST_ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0]      imem_rdata;
  logic                       inst_valid;
  logic [INST_WIDTH-1:0]      inst;
  logic [INST_ADDR_WIDTH-1:0] inst_pc;
  logic                       inst_ready;

  modport master (
    input  halt, branch, branch_addr, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output halt, branch, branch_addr, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Purpose: 2-entry buffer of fetched {inst, pc} pairs between imem and decode.
// Ports: clk, rst_n (async active-low); i_push/i_data write an entry;
//        i_pop drops the head; i_flush empties the buffer and overrides
//        push/pop; o_head is the oldest entry; o_count is occupancy (0..2).
module inst_fetch_fifo
  import inst_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  fetch_entry_t          i_data,
  output fetch_entry_t          o_head,
  output logic [FIFO_CNT_W-1:0] o_count
);

  fetch_entry_t          r_mem [FIFO_DEPTH];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [FIFO_CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) | w_do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + FIFO_CNT_W'(w_do_push) - FIFO_CNT_W'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Purpose: instruction fetch stage. Owns the PC, issues sequential imem reads
//          (fixed 1-cycle read latency) and buffers returned instructions for
//          decode behind a valid/ready handshake. halt stops fetching (and wins
//          over branch); branch redirects the PC and flushes buffered and
//          in-flight instructions.
// Ports: clk, rst_n (async active-low); bus (inst_fetch_if.master):
//          halt, branch, branch_addr in; imem_req, imem_addr out (combinational
//          from state, imem_req also from inst_ready); imem_rdata in;
//          inst_valid, inst, inst_pc out; inst_ready in.
// Optional: FETCH_PERF_CNT_EN adds perf_fetched (pops) and perf_flushes
//           (accepted branches), 16-bit saturating counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_fetch_if.master          bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetched,
  output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

  fetch_state_e               r_state;
  fetch_state_e               w_state_next;
  logic [INST_ADDR_WIDTH-1:0] r_pc;
  logic [INST_ADDR_WIDTH-1:0] w_pc_next;
  logic                       r_inflight;
  logic [INST_ADDR_WIDTH-1:0] r_inflight_pc;

  logic                       w_req;
  logic                       w_pop;
  logic                       w_branch_take;
  logic                       w_room;
  logic [OCC_W-1:0]           w_occ;
  logic [FIFO_CNT_W-1:0]      w_count;
  fetch_entry_t               w_head;
  fetch_entry_t               w_push_data;

  assign w_pop         = (w_count != '0) & bus.inst_ready;
  assign w_branch_take = bus.branch & ~bus.halt;

  // Room for another request once buffered + in-flight - leaving entries drop below 2.
  assign w_occ  = OCC_W'(w_count) + OCC_W'(r_inflight);
  assign w_room = w_occ < (OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop));

  // Next-state, PC update and request decision.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_req        = 1'b0;
    case (r_state)
      BOOT: begin
        if (bus.halt) begin
          w_state_next = HALTED;
        end else begin
          w_state_next = RUN;
          if (w_branch_take) w_pc_next = bus.branch_addr;
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_state_next = HALTED;
        end else if (w_branch_take) begin
          w_pc_next = bus.branch_addr;
        end else if (w_room) begin
          w_req     = 1'b1;
          w_pc_next = r_pc + INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
        end
      end
      HALTED: begin
        if (w_branch_take) begin
          w_state_next = RUN;
          w_pc_next    = bus.branch_addr;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  // State, PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_inflight <= w_req;
      if (w_req) r_inflight_pc <= r_pc;
    end
  end

  // The returning word is written unless a branch this cycle flushes it.
  assign w_push_data = '{inst: bus.imem_rdata, pc: r_inflight_pc};

  inst_fetch_fifo u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop & ~w_branch_take),
    .i_flush (w_branch_take),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = (w_count != '0);
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_perf_fetched;
  logic [PERF_CNT_W-1:0] r_perf_flushes;

  // Saturating event counters; a pop cancelled by a branch is not a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop && !w_branch_take && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + PERF_CNT_W'(1);
      if (w_branch_take && (r_perf_flushes != '1))
        r_perf_flushes <= r_perf_flushes + PERF_CNT_W'(1);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
